instr_cache: RTL

Direct-mapped, read-only instruction cache between the program counter and a slower multi-cycle backing memory, replacing the single-cycle instruction memory on the fetch path. A hit returns the instruction combinationally in the same cycle as `pc`. A miss raises `stall`, which the CPU already uses to hold the PC and the IF/ID register, while a fill FSM fetches the whole line one word per `mem_rvld` beat. Lines are invalidated together by `inv` or by reset.

---
 rtl/instr_cache.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache with a whole-line fill FSM.
// Define ICACHE_STATS_EN to build the saturating hit/miss counters.
module instr_cache #(
    parameter int unsigned INDEX_BITS  = 3,
    parameter int unsigned OFFSET_BITS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc,
    input  logic        rd_en,
    input  logic        inv,
    output logic [15:0] instr,
    output logic        stall,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rvld,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
);

    localparam int unsigned LINES      = 1 << INDEX_BITS;
    localparam int unsigned LINE_WORDS = 1 << OFFSET_BITS;
    localparam int unsigned TAG_BITS   = 16 - INDEX_BITS - OFFSET_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [LINES-1:0]       valid;
    logic [TAG_BITS-1:0]    tag_mem  [LINES];
    logic [15:0]            data_mem [LINES][LINE_WORDS];
    logic [TAG_BITS-1:0]    miss_tag;
    logic [INDEX_BITS-1:0]  miss_index;
    logic [OFFSET_BITS-1:0] beat_cnt;
    logic                   inv_pend;

    logic [OFFSET_BITS-1:0] pc_offset;
    logic [INDEX_BITS-1:0]  pc_index;
    logic [TAG_BITS-1:0]    pc_tag;
    logic                   idle;
    logic                   hit;
    logic                   miss;
    logic                   last_beat;
    logic [OFFSET_BITS-1:0] beat_nxt;

    assign pc_offset = pc[OFFSET_BITS-1:0];
    assign pc_index  = pc[OFFSET_BITS +: INDEX_BITS];
    assign pc_tag    = pc[15 -: TAG_BITS];

    // Lookup only happens in IDLE; fill states always stall the fetch.
    assign idle  = (state == IDLE);
    assign hit   = idle && rd_en && valid[pc_index] && (tag_mem[pc_index] == pc_tag);
    assign miss  = idle && rd_en && !hit;
    assign instr = hit ? data_mem[pc_index][pc_offset] : 16'h0000;
    assign stall = idle ? miss : 1'b1;

    assign last_beat = (beat_cnt == OFFSET_BITS'(LINE_WORDS - 1));
    assign beat_nxt  = beat_cnt + OFFSET_BITS'(1);

    // Fill FSM, valid bits and memory request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            valid      <= '0;
            beat_cnt   <= '0;
            inv_pend   <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            miss_tag   <= '0;
            miss_index <= '0;
        end else begin
            if (inv) begin
                valid <= '0;
            end
            case (state)
                IDLE: begin
                    inv_pend <= 1'b0;
                    if (miss) begin
                        miss_tag   <= pc_tag;
                        miss_index <= pc_index;
                        beat_cnt   <= '0;
                        mem_req    <= 1'b1;
                        mem_addr   <= {pc_tag, pc_index, OFFSET_BITS'(0)};
                        state      <= FILL;
                    end
                end
                FILL: begin
                    if (inv) begin
                        inv_pend <= 1'b1;
                    end
                    if (mem_rvld) begin
                        beat_cnt <= beat_nxt;
                        if (last_beat) begin
                            mem_req <= 1'b0;
                            state   <= DONE;
                        end else begin
                            mem_addr <= {miss_tag, miss_index, beat_nxt};
                        end
                    end
                end
                DONE: begin
                    // An invalidate seen during the fill leaves the line invalid.
                    if (!inv && !inv_pend) begin
                        valid[miss_index] <= 1'b1;
                    end
                    inv_pend <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line storage; readable only once the line is marked valid.
    always_ff @(posedge clk) begin
        if ((state == FILL) && mem_rvld) begin
            data_mem[miss_index][beat_cnt] <= mem_rdata;
        end
        if (state == DONE) begin
            tag_mem[miss_index] <= miss_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    // Saturating hit/miss statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit && (hit_cnt != 16'hFFFF)) begin
                hit_cnt <= hit_cnt + 16'd1;
            end
            if (miss && (miss_cnt != 16'hFFFF)) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end
`else
    assign hit_cnt  = 16'h0000;
    assign miss_cnt = 16'h0000;
`endif

endmodule
